// File: rtl/fa_resp_checker.sv
// On-chip response checker for a full adder: aligns stimulus to the adder's
// latency, compares against the expected sum/carry and keeps statistics.
module fa_resp_checker #(
   parameter int unsigned LAT   = 0,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             sum,
   input  logic             carry,
   input  logic             clear,
   output logic             chk_valid,
   output logic             chk_pass,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             err,
   output logic [4:0]       first_fail_vec,
   output logic [CNT_W-1:0] first_fail_idx
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic valid;
      logic a;
      logic b;
      logic c;
   } stage_t;

   stage_t           live_c;
   stage_t           cmp_c;
   logic             exp_sum_c;
   logic             exp_carry_c;
   logic             match_c;
   logic             fire_c;
   logic [CNT_W-1:0] idx_q;
   logic [CNT_W-1:0] pass_nxt_c;
   logic [CNT_W-1:0] fail_nxt_c;
   logic [CNT_W-1:0] idx_nxt_c;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      live_c = '{valid: in_valid, a: a, b: b, c: c};
   end

   // Delay line that lines the stimulus up with the adder's response
   generate
      if (LAT == 0) begin : g_no_delay
         assign cmp_c = live_c;
      end else begin : g_delay
         for (genvar s = 0; s < int'(LAT); s++) begin : g_stage
            stage_t d_c;
            stage_t q;
            if (s == 0) begin : g_head
               assign d_c = live_c;
            end else begin : g_tail
               assign d_c = g_stage[s-1].q;
            end
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  q <= '0;
               end else if (clear) begin
                  q <= '0;
               end else begin
                  q <= d_c;
               end
            end
         end
         assign cmp_c = g_stage[LAT-1].q;
      end
   endgenerate

   // Expected response; an unknown sum/carry fails the equality and reads as a mismatch
   always_comb begin
      exp_sum_c   = cmp_c.a ^ cmp_c.b ^ cmp_c.c;
      exp_carry_c = (cmp_c.a & cmp_c.b) | (cmp_c.a & cmp_c.c) | (cmp_c.b & cmp_c.c);
      match_c     = 1'b0;
      if ({sum, carry} == {exp_sum_c, exp_carry_c}) begin
         match_c = 1'b1;
      end
      fire_c      = cmp_c.valid & ~clear;
      pass_nxt_c  = sat_inc(pass_cnt);
      fail_nxt_c  = sat_inc(fail_cnt);
      idx_nxt_c   = sat_inc(idx_q);
   end

   // Result pulse, statistics and first-mismatch capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_valid      <= 1'b0;
         chk_pass       <= 1'b0;
         pass_cnt       <= '0;
         fail_cnt       <= '0;
         err            <= 1'b0;
         first_fail_vec <= '0;
         first_fail_idx <= '0;
         idx_q          <= '0;
      end else if (clear) begin
         chk_valid      <= 1'b0;
         chk_pass       <= 1'b0;
         pass_cnt       <= '0;
         fail_cnt       <= '0;
         err            <= 1'b0;
         first_fail_vec <= '0;
         first_fail_idx <= '0;
         idx_q          <= '0;
      end else begin
         chk_valid <= fire_c;
         if (fire_c) begin
            chk_pass <= match_c;
            idx_q    <= idx_nxt_c;
            if (match_c) begin
               pass_cnt <= pass_nxt_c;
            end else begin
               fail_cnt <= fail_nxt_c;
               if (!err) begin
                  err            <= 1'b1;
                  first_fail_vec <= {cmp_c.a, cmp_c.b, cmp_c.c, sum, carry};
                  first_fail_idx <= idx_q;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_fa_resp_checker.sv
// Randomized bench for fa_resp_checker: three instances (LAT 0/2/1) checked
// against a transaction-history reference model.
module tb_fa_resp_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b1;
   logic in_valid = 1'b0, a = 1'b0, b = 1'b0, c = 1'b0, clear = 1'b0;
   logic f0s = 1'b0, f0c = 1'b0, f1s = 1'b0, f1c = 1'b0;
   logic s0, c0;
   logic q1s = 1'b0, q1c = 1'b0, s1 = 1'b0, c1 = 1'b0;

   // Correct combinational adder with fault injection
   assign s0 = (a ^ b ^ c) ^ f0s;
   assign c0 = ((a & b) | (a & c) | (b & c)) ^ f0c;

   // Two-stage registered adder, faults travel with the data
   always @(posedge clk) begin
      q1s <= (a ^ b ^ c) ^ f1s;
      q1c <= ((a & b) | (a & c) | (b & c)) ^ f1c;
      s1  <= q1s;
      c1  <= q1c;
   end

   logic        cv0, cp0, er0, cv1, cp1, er1, cv2, cp2, er2;
   logic [15:0] pc0, fc0, fi0, pc2, fc2, fi2;
   logic [3:0]  pc1, fc1, fi1;
   logic [4:0]  fv0, fv1, fv2;

   fa_resp_checker #(.LAT(0), .CNT_W(16)) u_l0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c),
      .sum(s0), .carry(c0), .clear(clear), .chk_valid(cv0), .chk_pass(cp0),
      .pass_cnt(pc0), .fail_cnt(fc0), .err(er0), .first_fail_vec(fv0), .first_fail_idx(fi0));

   fa_resp_checker #(.LAT(2), .CNT_W(4)) u_l2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c),
      .sum(s1), .carry(c1), .clear(clear), .chk_valid(cv1), .chk_pass(cp1),
      .pass_cnt(pc1), .fail_cnt(fc1), .err(er1), .first_fail_vec(fv1), .first_fail_idx(fi1));

   fa_resp_checker #(.LAT(1), .CNT_W(16)) u_l1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c),
      .sum(s1), .carry(c1), .clear(clear), .chk_valid(cv2), .chk_pass(cp2),
      .pass_cnt(pc2), .fail_cnt(fc2), .err(er2), .first_fail_vec(fv2), .first_fail_idx(fi2));

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: history of sampled transactions plus per-instance statistics
   int         lat   [3] = '{0, 2, 1};
   int         m_max [3] = '{65535, 15, 65535};
   int         m_pass[3], m_fail[3], m_idx[3], m_ffi[3];
   logic       m_err [3], m_cv[3], m_cp[3];
   logic [4:0] m_ffv [3];
   logic       hv[64], ha[64], hb[64], hc[64];
   int         e     = 0;
   int         flush = 0;

   logic [2:0] order [8] = '{3'b000, 3'b001, 3'b110, 3'b011, 3'b100, 3'b101, 3'b010, 3'b111};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         m_pass[d] = 0; m_fail[d] = 0; m_idx[d] = 0; m_ffi[d] = 0;
         m_err[d] = 1'b0; m_cv[d] = 1'b0; m_cp[d] = 1'b0; m_ffv[d] = 5'd0;
      end
   endtask

   task automatic model_step();
      int         t;
      int         ones;
      logic       os, oc, ok;
      e++;
      for (int d = 0; d < 3; d++) m_cv[d] = 1'b0;
      hv[e % 64] = 1'b0;
      if (!rst_n) begin
         model_reset();
         flush = e;
         return;
      end
      if (clear) begin
         model_reset();
         flush = e;
      end
      hv[e % 64] = in_valid && !clear;
      ha[e % 64] = a; hb[e % 64] = b; hc[e % 64] = c;
      for (int d = 0; d < 3; d++) begin
         t = e - lat[d];
         if (t > flush && hv[t % 64]) begin
            os   = (d == 0) ? s0 : s1;
            oc   = (d == 0) ? c0 : c1;
            ones = int'(ha[t % 64]) + int'(hb[t % 64]) + int'(hc[t % 64]);
            ok   = ({oc, os} === 2'(ones));
            m_cv[d] = 1'b1;
            m_cp[d] = ok;
            if (ok) begin
               if (m_pass[d] < m_max[d]) m_pass[d]++;
            end else begin
               if (m_fail[d] < m_max[d]) m_fail[d]++;
               if (!m_err[d]) begin
                  m_err[d] = 1'b1;
                  m_ffv[d] = {ha[t % 64], hb[t % 64], hc[t % 64], os, oc};
                  m_ffi[d] = m_idx[d];
               end
            end
            if (m_idx[d] < m_max[d]) m_idx[d]++;
         end
      end
   endtask

   task automatic check_dut(input int d, input logic cv, input logic cp, input logic [15:0] pc,
                            input logic [15:0] fc, input logic [15:0] fi, input logic er,
                            input logic [4:0] fv);
      check($sformatf("d%0d chk_valid", d), 32'(cv), 32'(m_cv[d]));
      if (m_cv[d]) check($sformatf("d%0d chk_pass", d), 32'(cp), 32'(m_cp[d]));
      check($sformatf("d%0d pass_cnt", d), 32'(pc), 32'(m_pass[d]));
      check($sformatf("d%0d fail_cnt", d), 32'(fc), 32'(m_fail[d]));
      check($sformatf("d%0d err", d), 32'(er), 32'(m_err[d]));
      check($sformatf("d%0d first_fail_vec", d), 32'(fv), 32'(m_ffv[d]));
      check($sformatf("d%0d first_fail_idx", d), 32'(fi), 32'(m_ffi[d]));
   endtask

   task automatic check_all();
      check_dut(0, cv0, cp0, pc0, fc0, fi0, er0, fv0);
      check_dut(1, cv1, cp1, {12'd0, pc1}, {12'd0, fc1}, {12'd0, fi1}, er1, fv1);
      check_dut(2, cv2, cp2, pc2, fc2, fi2, er2, fv2);
   endtask

   task automatic check_zero();
      check("rst d0 outputs", 32'({cv0, cp0, pc0, fc0, er0, fv0}), 32'd0);
      check("rst d0 idx", 32'(fi0), 32'd0);
      check("rst d1 outputs", 32'({cv1, cp1, pc1, fc1, er1, fv1, fi1}), 32'd0);
      check("rst d2 outputs", 32'({cv2, cp2, pc2, fc2, er2, fv2}), 32'd0);
      check("rst d2 idx", 32'(fi2), 32'd0);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic drain();
      in_valid = 1'b0;
      f0s = 1'b0; f0c = 1'b0; f1s = 1'b0; f1c = 1'b0;
      repeat (3) cycle();
   endtask

   task automatic pulse_clear();
      in_valid = 1'b0;
      clear = 1'b1;
      cycle();
      clear = 1'b0;
   endtask

   task automatic run8(input logic [7:0] mask);
      for (int i = 0; i < 8; i++) begin
         {a, b, c} = order[i];
         in_valid  = 1'b1;
         f0c       = mask[i];
         cycle();
      end
      drain();
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must drop before any edge
   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      model_reset();
      flush = e;
      #1;
      check_zero();
      cycle();
      cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) hv[i] = 1'b0;
      model_reset();
      #1 rst_n = 1'b0;
      #1 check_zero();
      repeat (2) cycle();
      rst_n = 1'b1;
      cycle();

      // Exhaustive vectors with carry inverted on the third transaction (110)
      run8(8'b0000_0100);
      check("single d0 pass_cnt", 32'(pc0), 32'd7);
      check("single d0 fail_cnt", 32'(fc0), 32'd1);
      check("single d0 err", 32'(er0), 32'd1);
      check("single d0 first_fail_vec", 32'(fv0), 32'b11000);
      check("single d0 first_fail_idx", 32'(fi0), 32'd2);
      check("lat2 d1 pass_cnt", 32'(pc1), 32'd8);
      check("lat2 d1 err", 32'(er1), 32'd0);
      check("lat1 d2 err", 32'(er2), 32'd1);

      // Faults at indices 2 and 5
      pulse_clear();
      run8(8'b0010_0100);
      check("multi d0 fail_cnt", 32'(fc0), 32'd2);
      check("multi d0 first_fail_idx", 32'(fi0), 32'd2);
      check("multi d0 first_fail_vec", 32'(fv0), 32'b11000);

      // Clear with two transactions in flight
      pulse_clear();
      {a, b, c} = 3'b111; in_valid = 1'b1; cycle();
      {a, b, c} = 3'b011; cycle();
      in_valid = 1'b0; clear = 1'b1; cycle(); clear = 1'b0;
      drain();
      check("clear d1 pass_cnt", 32'(pc1), 32'd0);
      check("clear d0 pass_cnt", 32'(pc0), 32'd0);

      // Same stream interrupted by reset
      {a, b, c} = 3'b111; in_valid = 1'b1; cycle();
      {a, b, c} = 3'b011; cycle();
      in_valid = 1'b0;
      async_reset();
      drain();

      // Saturation of the 4-bit instance
      for (int i = 0; i < 20; i++) begin
         {a, b, c} = 3'($urandom);
         in_valid  = 1'b1;
         cycle();
      end
      drain();
      check("sat d1 pass_cnt", 32'(pc1), 32'd15);
      check("sat d1 fail_cnt", 32'(fc1), 32'd0);
      {a, b, c} = 3'b101; in_valid = 1'b1; f1c = 1'b1;
      cycle();
      drain();
      check("sat d1 fail_cnt after fault", 32'(fc1), 32'd1);
      check("sat d1 first_fail_idx", 32'(fi1), 32'd15);
      check("sat d1 err", 32'(er1), 32'd1);

      // Random traffic with faults, clears and resets
      for (int n = 0; n < 3000; n++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 2) async_reset();
         clear     = (r >= 2 && r < 4);
         in_valid  = ($urandom_range(0, 99) < 70);
         {a, b, c} = 3'($urandom);
         f0s       = ($urandom_range(0, 99) < 5);
         f0c       = ($urandom_range(0, 99) < 5);
         f1s       = ($urandom_range(0, 99) < 5);
         f1c       = ($urandom_range(0, 99) < 5);
         cycle();
      end
      clear = 1'b0;
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fa_resp_checker.md
# fa_resp_checker

- Synthesizable response checker for the full-adder datapath.
- Watches the stimulus applied to a full adder (a, b, c) and the adder's response (sum, carry), and computes the expected response itself.
- Compares expected against actual and keeps pass/fail statistics plus a capture of the first mismatch.
- Sits beside the adder as an on-chip self-check, replacing the software scoreboard in silicon or emulation.

## Interface

Parameters:
- LAT, default 0: adder response latency in clock cycles; legal range 0..7.
- CNT_W, default 16: width of the pass/fail counters and the transaction index.

Ports:
- clk  in  1: single clock; all state updates on its rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- in_valid  in  1: a, b, c carry a transaction this cycle.
- a, b, c  in  1 each: stimulus bits applied to the adder.
- sum, carry  in  1 each: the adder's response.
- clear  in  1: synchronous clear of all statistics and in-flight transactions.
- chk_valid  out  1: one-cycle pulse, a compare result is available.
- chk_pass  out  1: result of that compare; 1 = match. Meaningful only while chk_valid = 1.
- pass_cnt  out  CNT_W: number of matching compares, saturating.
- fail_cnt  out  CNT_W: number of mismatching compares, saturating.
- err  out  1: sticky flag, set on the first mismatch.
- first_fail_vec  out  5: {a, b, c, sum, carry} of the first mismatching transaction.
- first_fail_idx  out  CNT_W: zero-based transaction index of the first mismatch.

## Operation

Reset and clear:
- Reset (rst_n = 0, asynchronous) drives every output to 0 and empties the delay line.
- clear = 1 has the same effect synchronously at the next edge.
- clear takes priority over any compare due at that edge. That compare is discarded: it does not count, and chk_valid stays 0.

Delay line:
- LAT stages, each holding {valid, a, b, c}. in_valid and a/b/c enter stage 1.
- LAT = 0: no stages; the compare uses the live a/b/c/in_valid.

Compare:
- Occurs at an edge where the last stage is valid (or in_valid = 1 when LAT = 0).
- Expected sum = a ^ b ^ c. Expected carry = (a & b) | (a & c) | (b & c).
- Match means both bits are equal to the sampled sum and carry.

Results of a compare:
- chk_valid = 1 and chk_pass = match, registered and valid for exactly one cycle.
- Match: pass_cnt increments. Mismatch: fail_cnt increments.
- Both counters saturate at 2^CNT_W - 1 and never wrap.

First-fail capture:
- An internal transaction index counts all compares, passing or failing. It saturates like the counters.
- On a mismatch while err = 0: err is set, first_fail_vec takes the sampled {a, b, c, sum, carry}, and first_fail_idx takes the current index.
- Later mismatches update fail_cnt only; the capture is not changed.
- err clears only on reset or clear.

Other rules:
- Outputs hold their values between compares.
- X/Z on sum or carry during a compare counts as a mismatch.

## Timing

- A transaction sampled with in_valid at edge k is compared at edge k + LAT, using the sum/carry values present at that edge.
- chk_valid, chk_pass, the counters, err and the capture all update at edge k + LAT. They are visible in the cycle that follows.
- Throughput is one transaction per cycle. Back-to-back in_valid produces back-to-back chk_valid pulses.
- clear asserted at edge j flushes every transaction sampled before j. The first transaction after it can be sampled at edge j + 1.
- Reset mid-stream: no chk_valid pulse is produced for any transaction sampled before reset deasserts.
- Deassertion of rst_n takes effect at the next edge; no transaction is sampled at that same edge.

## Test plan

- Exhaustive pass, LAT = 0: all 8 {a, b, c} combinations driven on consecutive cycles against a correct combinational adder. Expect 8 chk_valid pulses with chk_pass = 1, then pass_cnt = 8, fail_cnt = 0, err = 0.
- Single fault: carry is inverted only on the 3rd transaction, a=1 b=1 c=0. Expect fail_cnt = 1, pass_cnt = 7, err = 1, first_fail_vec = 5'b11000 (the reported sum=0 with the inverted carry=0), first_fail_idx = 2.
- Multiple faults: mismatches at indices 2 and 5. Expect fail_cnt = 2; first_fail_idx stays 2 and first_fail_vec still holds the index-2 values.
- Latency alignment: LAT = 2 against a 2-stage registered adder, 8 vectors. Expect 8 passes, with the first chk_valid 2 cycles after the first in_valid. Rerun with LAT = 1 against the same adder: expect at least one mismatch and err = 1.
- Saturation: CNT_W = 4, 20 correct transactions. Expect pass_cnt = 15 with no wrap; a following mismatch gives fail_cnt = 1 and first_fail_idx = 15.
- Clear and reset: with LAT = 2 and two transactions in flight, pulse clear. Expect no chk_valid afterwards and all outputs 0. Repeat the same stream with rst_n pulsed low mid-stream: expect the same result immediately, without waiting for a clock edge.
